// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file: Status/Cause/EPC/Count/Compare/BadVAddr/Config, precise exception capture,
// prescaled Count/Compare timer, masked interrupt request and MTC0->MFC0 forwarding from younger stages.
module cp0_regfile #(
  parameter int          NUM_BYPASS = 4,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] CONFIG_VAL = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [4:0]              waddr_i,
  input  logic [2:0]              wsel_i,
  input  logic [31:0]             wdata_i,
  input  logic [4:0]              raddr_i,
  input  logic [2:0]              rsel_i,
  output logic [31:0]             rdata_o,
  input  logic [5:0]              hw_int_i,
  input  logic                    exc_valid_i,
  input  logic [4:0]              exc_code_i,
  input  logic [31:0]             exc_pc_i,
  input  logic                    exc_bd_i,
  input  logic                    exc_bva_valid_i,
  input  logic [31:0]             exc_bva_i,
  input  logic                    eret_i,
  input  logic [41*NUM_BYPASS-1:0] byp_bus_i,
  output logic [31:0]             status_o,
  output logic [31:0]             cause_o,
  output logic [31:0]             epc_o,
  output logic                    int_req_o,
  output logic                    timer_int_o
);

  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic        r_ti;
  logic [7:2]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [3:0]  r_presc;

  logic        w_mtc0;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic [31:0] w_arch_rdata;

  assign status_o    = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign cause_o     = {r_bd, r_ti, 14'b0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b0};
  assign epc_o       = r_epc;
  assign timer_int_o = r_ti;
  assign int_req_o   = r_ie & ~r_exl & |({r_ip_hw, r_ip_sw} & r_im);

  // An exception or ERET in the same cycle drops the MTC0 completely.
  assign w_mtc0       = we_i & (wsel_i == 3'd0) & ~exc_valid_i & ~eret_i;
  assign w_wr_count   = w_mtc0 & (waddr_i == 5'd9);
  assign w_wr_compare = w_mtc0 & (waddr_i == 5'd11);

  always_comb begin
    w_arch_rdata = '0;
    if (rsel_i == 3'd0) begin
      case (raddr_i)
        5'd8:    w_arch_rdata = r_badvaddr;
        5'd9:    w_arch_rdata = r_count;
        5'd11:   w_arch_rdata = r_compare;
        5'd12:   w_arch_rdata = status_o;
        5'd13:   w_arch_rdata = cause_o;
        5'd14:   w_arch_rdata = r_epc;
        5'd16:   w_arch_rdata = CONFIG_VAL;
        default: w_arch_rdata = '0;
      endcase
    end
  end

  // Scan oldest to youngest so the lowest matching index overrides last.
  always_comb begin
    rdata_o = w_arch_rdata;
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      if (byp_bus_i[41*k+40] && (byp_bus_i[41*k+35 +: 5] == raddr_i) &&
          (byp_bus_i[41*k+32 +: 3] == rsel_i))
        rdata_o = byp_bus_i[41*k +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ti       <= 1'b0;
      r_ip_hw    <= '0;
      r_ip_sw    <= '0;
      r_exccode  <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_presc    <= '0;
    end else begin
      r_ip_hw <= {hw_int_i[5] | r_ti, hw_int_i[4:0]};

      if (w_wr_count) begin
        r_count <= wdata_i;
        r_presc <= '0;
      end else if (r_presc == DIV_LAST) begin
        r_count <= r_count + 32'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 4'd1;
      end

      if (w_wr_compare) begin
        r_compare <= wdata_i;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end

      if (exc_valid_i) begin
        if (!r_exl) begin
          r_epc <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
          r_bd  <= exc_bd_i;
        end
        r_exccode <= exc_code_i;
        r_exl     <= 1'b1;
        if (exc_bva_valid_i) r_badvaddr <= exc_bva_i;
      end else if (eret_i) begin
        r_exl <= 1'b0;
      end else if (w_mtc0) begin
        case (waddr_i)
          5'd12: begin
            r_im  <= wdata_i[15:8];
            r_exl <= wdata_i[1];
            r_ie  <= wdata_i[0];
          end
          5'd13:   r_ip_sw <= wdata_i[9:8];
          5'd14:   r_epc   <= wdata_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (COUNT_DIV = 2, four bypass entries).
module tb_cp0_regfile;
  localparam int          NB  = 4;
  localparam logic [31:0] CFG = 32'hC0DE_0001;

  logic            clk = 1'b0;
  logic            rst;
  logic            we_i;
  logic [4:0]      waddr_i;
  logic [2:0]      wsel_i;
  logic [31:0]     wdata_i;
  logic [4:0]      raddr_i;
  logic [2:0]      rsel_i;
  logic [31:0]     rdata_o;
  logic [5:0]      hw_int_i;
  logic            exc_valid_i;
  logic [4:0]      exc_code_i;
  logic [31:0]     exc_pc_i;
  logic            exc_bd_i;
  logic            exc_bva_valid_i;
  logic [31:0]     exc_bva_i;
  logic            eret_i;
  logic [41*NB-1:0] byp_bus_i;
  logic [31:0]     status_o, cause_o, epc_o;
  logic            int_req_o, timer_int_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cp0_regfile #(.NUM_BYPASS(NB), .COUNT_DIV(2), .CONFIG_VAL(CFG)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wsel_i(wsel_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rsel_i(rsel_i), .rdata_o(rdata_o), .hw_int_i(hw_int_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
    .exc_bva_valid_i(exc_bva_valid_i), .exc_bva_i(exc_bva_i), .eret_i(eret_i),
    .byp_bus_i(byp_bus_i), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .int_req_o(int_req_o), .timer_int_o(timer_int_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic [2:0] s = 3'd0);
    we_i = 1'b1; waddr_i = a; wsel_i = s; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    raddr_i = a; rsel_i = 3'd0;
    #1;
    d = rdata_o;
  endtask

  function automatic logic [40:0] ent(input logic v, input logic [4:0] a, input logic [2:0] s,
                                      input logic [31:0] d);
    return {v, a, s, d};
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    tick(); tick();
    rd(5'd12, d);
    n_vec++; if (d !== 32'h0040_0000) begin n_err++; $display("FAIL rst_status got %h want 00400000", d); end
    rd(5'd13, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_cause got %h want 00000000", d); end
    rd(5'd16, d);
    n_vec++; if (d !== CFG) begin n_err++; $display("FAIL rst_config got %h want %h", d, CFG); end
    rd(5'd9, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_count got %h want 0", d); end
    n_vec++; if ({int_req_o, timer_int_o, epc_o} !== 34'h0) begin
      n_err++; $display("FAIL rst_outs got %b%b %h want 00 0", int_req_o, timer_int_o, epc_o); end
    rst = 1'b0;
  endtask

  task automatic test_status_write();
    logic [31:0] d;
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, d);
    n_vec++; if (d !== 32'h0040_FF03) begin n_err++; $display("FAIL status_mask got %h want 0040ff03", d); end
    mtc0(5'd12, 32'h0);
    n_vec++; if (status_o !== 32'h0040_0000) begin n_err++; $display("FAIL status_clr got %h want 00400000", status_o); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    mtc0(5'd11, 32'hFFFF_0000);   // keep TI and IP7 clear
    tick();
    exc_valid_i = 1'b1; exc_pc_i = 32'hBFC0_0100; exc_bd_i = 1'b1; exc_code_i = 5'd4;
    exc_bva_valid_i = 1'b1; exc_bva_i = 32'h1234_5678;
    tick();
    exc_valid_i = 1'b0; exc_bva_valid_i = 1'b0;
    n_vec++; if (epc_o !== 32'hBFC0_00FC) begin n_err++; $display("FAIL exc1_epc got %h want bfc000fc", epc_o); end
    n_vec++; if (cause_o !== 32'h8000_0010) begin n_err++; $display("FAIL exc1_cause got %h want 80000010", cause_o); end
    rd(5'd8, d);
    n_vec++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL exc1_bva got %h want 12345678", d); end
    n_vec++; if (status_o[1] !== 1'b1) begin n_err++; $display("FAIL exc1_exl got %b want 1", status_o[1]); end
    exc_valid_i = 1'b1; exc_pc_i = 32'h0000_0040; exc_bd_i = 1'b0; exc_code_i = 5'd5;
    exc_bva_i = 32'hAAAA_AAAA;
    tick();
    exc_valid_i = 1'b0;
    n_vec++; if (epc_o !== 32'hBFC0_00FC) begin n_err++; $display("FAIL exc2_epc got %h want bfc000fc", epc_o); end
    n_vec++; if (cause_o !== 32'h8000_0014) begin n_err++; $display("FAIL exc2_cause got %h want 80000014", cause_o); end
    rd(5'd8, d);
    n_vec++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL exc2_bva got %h want 12345678", d); end
    eret_i = 1'b1;
    tick();
    eret_i = 1'b0;
    n_vec++; if (status_o !== 32'h0040_0000) begin n_err++; $display("FAIL eret_status got %h want 00400000", status_o); end
  endtask

  task automatic test_priority();
    exc_valid_i = 1'b1; exc_pc_i = 32'h0000_1000; exc_bd_i = 1'b0; exc_code_i = 5'd2;
    eret_i = 1'b1; we_i = 1'b1; waddr_i = 5'd14; wsel_i = 3'd0; wdata_i = 32'hDEAD_BEEF;
    tick();
    exc_valid_i = 1'b0; eret_i = 1'b0; we_i = 1'b0;
    n_vec++; if (epc_o !== 32'h0000_1000) begin n_err++; $display("FAIL prio_epc got %h want 00001000", epc_o); end
    n_vec++; if (status_o[1] !== 1'b1) begin n_err++; $display("FAIL prio_exl got %b want 1", status_o[1]); end
    n_vec++; if (cause_o !== 32'h0000_0008) begin n_err++; $display("FAIL prio_cause got %h want 00000008", cause_o); end
    eret_i = 1'b1; we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h5555_0000;
    tick();
    eret_i = 1'b0; we_i = 1'b0;
    n_vec++; if ({status_o[1], epc_o} !== {1'b0, 32'h0000_1000}) begin
      n_err++; $display("FAIL eret_beats_mtc0 got %b %h want 0 00001000", status_o[1], epc_o); end
  endtask

  task automatic test_mtc0_misc();
    logic [31:0] d;
    we_i = 1'b1; waddr_i = 5'd14; wsel_i = 3'd0; wdata_i = 32'h0BAD_F00D;
    rd(5'd14, d);
    n_vec++; if (d !== 32'h0000_1000) begin n_err++; $display("FAIL same_cycle_read got %h want 00001000", d); end
    tick();
    we_i = 1'b0;
    rd(5'd14, d);
    n_vec++; if (d !== 32'h0BAD_F00D) begin n_err++; $display("FAIL next_cycle_read got %h want 0badf00d", d); end
    mtc0(5'd14, 32'h7777_7777, 3'd1);
    mtc0(5'd8, 32'h7777_7777);
    mtc0(5'd16, 32'h7777_7777);
    rd(5'd14, d);
    n_vec++; if (d !== 32'h0BAD_F00D) begin n_err++; $display("FAIL sel1_write got %h want 0badf00d", d); end
    rd(5'd8, d);
    n_vec++; if (d !== 32'h1234_5678) begin n_err++; $display("FAIL ro_bva got %h want 12345678", d); end
    rd(5'd16, d);
    n_vec++; if (d !== CFG) begin n_err++; $display("FAIL ro_config got %h want %h", d, CFG); end
    raddr_i = 5'd14; rsel_i = 3'd2; #1;
    n_vec++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL sel2_read got %h want 0", rdata_o); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    n_vec++; if (cause_o[9:8] !== 2'b11 || cause_o[31:30] !== 2'b00) begin
      n_err++; $display("FAIL cause_write got %h want IP1:0=11 BD/TI=0", cause_o); end
    mtc0(5'd13, 32'h0);
  endtask

  task automatic test_timer();
    logic [31:0] d;
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'h0);
    repeat (10) tick();
    rd(5'd9, d);
    n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL count_at_10 got %h want 5", d); end
    n_vec++; if (timer_int_o !== 1'b0) begin n_err++; $display("FAIL ti_at_10 got %b want 0", timer_int_o); end
    tick();
    n_vec++; if (timer_int_o !== 1'b1) begin n_err++; $display("FAIL ti_at_11 got %b want 1", timer_int_o); end
    tick();
    n_vec++; if (cause_o[15] !== 1'b1) begin n_err++; $display("FAIL ip7 got %b want 1", cause_o[15]); end
    n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL int_masked got %b want 0", int_req_o); end
    mtc0(5'd12, 32'h0000_8001);
    n_vec++; if (int_req_o !== 1'b1) begin n_err++; $display("FAIL int_timer got %b want 1", int_req_o); end
    mtc0(5'd11, 32'd1000);
    n_vec++; if (timer_int_o !== 1'b0) begin n_err++; $display("FAIL ti_clear got %b want 0", timer_int_o); end
  endtask

  task automatic test_hw_int();
    mtc0(5'd12, 32'h0000_0401);
    tick();
    hw_int_i = 6'b000001;
    #1;
    n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL hw_int_early got %b want 0", int_req_o); end
    tick();
    n_vec++; if (int_req_o !== 1'b1) begin n_err++; $display("FAIL hw_int got %b want 1", int_req_o); end
    mtc0(5'd12, 32'h0000_0403);
    n_vec++; if (int_req_o !== 1'b0) begin n_err++; $display("FAIL hw_int_exl got %b want 0", int_req_o); end
    hw_int_i = 6'b0;
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_count_wrap();
    logic [31:0] d;
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick();
    rd(5'd9, d);
    n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_hold got %h want ffffffff", d); end
    tick();
    rd(5'd9, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL wrap_zero got %h want 0", d); end
    tick();
    mtc0(5'd9, 32'h0000_0100);
    rd(5'd9, d);
    n_vec++; if (d !== 32'h0000_0100) begin n_err++; $display("FAIL load_on_wrap got %h want 00000100", d); end
    tick();
    rd(5'd9, d);
    n_vec++; if (d !== 32'h0000_0100) begin n_err++; $display("FAIL presc_reset got %h want 00000100", d); end
    tick();
    rd(5'd9, d);
    n_vec++; if (d !== 32'h0000_0101) begin n_err++; $display("FAIL inc_after_load got %h want 00000101", d); end
  endtask

  task automatic test_bypass();
    byp_bus_i = {ent(1'b0, 5'd0, 3'd0, 32'h0), ent(1'b1, 5'd14, 3'd0, 32'h2222_2222),
                 ent(1'b0, 5'd14, 3'd0, 32'h3333_3333), ent(1'b1, 5'd14, 3'd0, 32'h1111_1111)};
    raddr_i = 5'd14; rsel_i = 3'd0; #1;
    n_vec++; if (rdata_o !== 32'h1111_1111) begin n_err++; $display("FAIL byp_prio got %h want 11111111", rdata_o); end
    rsel_i = 3'd1; #1;
    n_vec++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL byp_sel1 got %h want 0", rdata_o); end
    byp_bus_i[40] = 1'b0;
    rsel_i = 3'd0; #1;
    n_vec++; if (rdata_o !== 32'h2222_2222) begin n_err++; $display("FAIL byp_entry2 got %h want 22222222", rdata_o); end
    byp_bus_i = {ent(1'b1, 5'd12, 3'd0, 32'hFFFF_FFFF), 123'h0};
    raddr_i = 5'd12; #1;
    n_vec++; if (rdata_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL byp_raw got %h want ffffffff", rdata_o); end
    byp_bus_i = '0;
    #1;
    n_vec++; if (rdata_o !== 32'h0040_0000) begin n_err++; $display("FAIL byp_none got %h want 00400000", rdata_o); end
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; wsel_i = '0; wdata_i = '0; raddr_i = '0; rsel_i = '0;
    hw_int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0; exc_bd_i = 1'b0;
    exc_bva_valid_i = 1'b0; exc_bva_i = '0; eret_i = 1'b0; byp_bus_i = '0;
    test_reset();
    test_status_write();
    test_exception();
    test_priority();
    test_mtc0_misc();
    test_timer();
    test_hw_int();
    test_count_wrap();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Parametrised MIPS32 CP0 register file for the August_CPU pipeline. It holds Status, Cause, EPC, Count, Compare, BadVAddr and Config, and records precise exceptions with ExcCode, EPC, branch-delay and BadVAddr capture. It also runs a prescaled Count/Compare timer with clear-on-Compare-write, generates the masked interrupt request, and forwards in-flight MTC0 data from a configurable number of younger pipeline stages to the MFC0 read port. It sits beside the memory stage, which drives its exception, ERET, MTC0 and MFC0 signals.

## Interface
Parameters:
- NUM_BYPASS, 4: number of forwarding entries on byp_bus_i. Index 0 is the youngest and has the highest priority.
- COUNT_DIV, 2: Count increments once every COUNT_DIV clk cycles. Legal range 1..16.
- CONFIG_VAL, 32'h0000_0000: constant value read from Config (reg 16, sel 0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  write register number.
- wsel_i  in  3  write select.
- wdata_i  in  32  write data.
- raddr_i  in  5  read register number.
- rsel_i  in  3  read select.
- rdata_o  out  32  read data; combinational.
- hw_int_i  in  6  external interrupt lines, level-sensitive, already synchronised.
- exc_valid_i  in  1  commit an exception this cycle.
- exc_code_i  in  5  ExcCode; 0 means interrupt.
- exc_pc_i  in  32  PC of the faulting instruction.
- exc_bd_i  in  1  faulting instruction is in a delay slot.
- exc_bva_valid_i  in  1  update BadVAddr.
- exc_bva_i  in  32  faulting virtual address.
- eret_i  in  1  commit ERET.
- byp_bus_i  in  41*NUM_BYPASS  per entry {valid, addr[4:0], sel[2:0], data[31:0]}; entry k occupies bits [41k+40:41k].
- status_o  out  32  Status.
- cause_o  out  32  Cause.
- epc_o  out  32  EPC.
- int_req_o  out  1  interrupt pending and enabled.
- timer_int_o  out  1  Cause.TI.

## Operation
- Only sel 0 is implemented. Any access with sel≠0 reads 0, and writes to it are ignored.
- Register map: BadVAddr 8 (read-only), Count 9, Compare 11, Status 12, Cause 13, EPC 14, Config 16 (read-only). Any other register number reads 0.
- Status: writable bits are IM[15:8], EXL[1] and IE[0]. BEV[22] is constant 1. All other bits read 0. Reset value 32'h0040_0000.
- Cause fields:
  - BD[31] and ExcCode[6:2] are hardware-written only.
  - TI[30] is hardware-written only.
  - IP[7:2] is loaded every cycle with {hw_int_i[5] | TI, hw_int_i[4:0]}.
  - IP[1:0] is software-writable.
  - Reset value 0.
- Exception (exc_valid_i = 1):
  - If EXL = 0: EPC ← exc_bd_i ? exc_pc_i−4 : exc_pc_i, and BD ← exc_bd_i.
  - If EXL = 1: EPC and BD are left unchanged.
  - In both cases: ExcCode ← exc_code_i and EXL ← 1.
  - If exc_bva_valid_i = 1: BadVAddr ← exc_bva_i.
- ERET: EXL ← 0.
- Same-cycle priority: exception wins over ERET, which wins over MTC0. The losing actions are dropped entirely.
- MTC0 to a read-only or unimplemented register is a no-op.
- Count:
  - A prescaler counts 0..COUNT_DIV−1; Count increments on wrap.
  - Count is 32-bit and wraps from FFFF_FFFF to 0.
  - An MTC0 to Count loads wdata_i, resets the prescaler to 0, and suppresses that cycle's increment.
- Timer interrupt:
  - TI ← 1 on any cycle where Count == Compare, evaluated on the registered values.
  - An MTC0 to Compare loads Compare and clears TI. The clear wins over a same-cycle set.
  - Compare == 0 is not special.
- int_req_o = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- timer_int_o = TI.
- Read port:
  - rdata_o is the data of the lowest-index bypass entry with valid = 1, addr == raddr_i and sel == rsel_i.
  - Forwarded data is raw and not write-masked.
  - If no entry matches, rdata_o is the architectural register value.
  - The read path is purely combinational and does not depend on rst.

## Timing
- All state updates on posedge clk.
- rst reset values:
  - Count, Compare, EPC, BadVAddr, Cause and the prescaler are 0.
  - Status is 32'h0040_0000.
  - int_req_o and timer_int_o are 0.
- rst applied mid-operation discards any same-cycle exception, ERET or write.
- Write-to-read latency through architectural state is 1 cycle: a write in cycle N is visible on rdata_o in cycle N+1. Same-cycle visibility is provided only by the bypass bus.
- TI rises 1 cycle after Count == Compare.
- int_req_o responds to a hw_int_i change after 1 cycle, because IP is registered, and is combinational in Status.
- Exception and ERET effects are visible on status_o, cause_o and epc_o the cycle after commit.

## Test plan
- Reset, then read regs 12, 13 and 16 → 0040_0000, 0000_0000, CONFIG_VAL. Write reg 12 with FFFF_FFFF → reads 0040_FF03.
- Exception with pc = BFC0_0100, bd = 1, code = 4, bva = 1234_5678 → EPC BFC0_00FC, Cause 8000_0010, BadVAddr 1234_5678, EXL 1. A second exception with pc = 0000_0040, bd = 0 → EPC and BD unchanged, ExcCode updated.
- Same-cycle exception, ERET and MTC0 EPC = DEAD_BEEF → exception result only, EXL = 1, EPC ≠ DEAD_BEEF.
- COUNT_DIV = 2, Compare = 5, Count = 0 → Count reaches 5 at cycle 10, TI = 1 at cycle 11, IP7 = 1. Status = 0000_8001 → int_req_o = 1. Write Compare → TI = 0 next cycle.
- Count = FFFF_FFFF → wraps to 0 after COUNT_DIV cycles. MTC0 Count on a prescaler-wrap cycle → loaded value, no increment.
- Bypass entries 0 and 2 both valid for reg 14 with data 1111_1111 and 2222_2222 → rdata 1111_1111. Same entries with rsel = 1 → rdata 0.
